// File: rtl/clocked_priority_arbiter_16.sv
// clocked_priority_arbiter_16
//   Sixteen-way arbiter with registered outputs. It offers fixed-priority mode
//   (highest index wins) and round-robin mode (the search starts just below the
//   last winner and descends with wraparound). A tenure continues while the
//   granted requester holds its request line, up to MAX_HOLD cycles. After every
//   tenure there is one GAP cycle with no grant.
//
//   state | meaning
//   IDLE  | nothing granted; arbitrate on each edge
//   GRANT | grant held for requester grant_id; hold_cnt counts tenure cycles
//   GAP   | one dead cycle after a tenure; arbitrate on the next edge
//
// Ports
//   clk         : clock, rising edge
//   reset       : asynchronous reset, active low
//   req[15:0]   : request lines
//   rr_en       : 0 = fixed priority, 1 = round-robin
//   grant[15:0] : registered one-hot grant
//   grant_id    : registered index of the granted requester
//   grant_valid : registered, high while a grant is held
//   timeout     : registered one-cycle pulse in the GAP after a MAX_HOLD ending
module clocked_priority_arbiter_16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic        rr_en,
  output logic [15:0] grant,
  output logic [3:0]  grant_id,
  output logic        grant_valid,
  output logic        timeout
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [3:0]  last_id, last_id_nxt;
  logic [7:0]  hold_cnt, hold_cnt_nxt;
  logic [15:0] grant_nxt;
  logic [3:0]  id_nxt;
  logic        valid_nxt, timeout_nxt;

  logic        win_any;
  logic [3:0]  win_id;
  logic [3:0]  idx;

  // Winner search. In round-robin mode the walk starts at last_id-1 and
  // descends. The 4-bit arithmetic wraps 0 -> 15, so last_id is visited last.
  always_comb begin
    win_any = 1'b0;
    win_id  = 4'd0;
    idx     = 4'd0;
    if (rr_en) begin
      for (int k = 0; k < 16; k++) begin
        idx = last_id - 4'd1 - k[3:0];
        if (!win_any && req[idx]) begin
          win_any = 1'b1;
          win_id  = idx;
        end
      end
    end else begin
      for (int i = 15; i >= 0; i--) begin
        if (!win_any && req[i]) begin
          win_any = 1'b1;
          win_id  = 4'(i);
        end
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    id_nxt       = grant_id;
    valid_nxt    = grant_valid;
    timeout_nxt  = 1'b0;
    hold_cnt_nxt = hold_cnt;
    last_id_nxt  = last_id;
    case (state)
      IDLE, GAP: begin
        if (win_any) begin
          state_nxt    = GRANT;
          grant_nxt    = 16'd1 << win_id;
          id_nxt       = win_id;
          valid_nxt    = 1'b1;
          hold_cnt_nxt = 8'd1;
          last_id_nxt  = win_id;
        end else begin
          state_nxt    = IDLE;
          grant_nxt    = 16'd0;
          id_nxt       = 4'd0;
          valid_nxt    = 1'b0;
          hold_cnt_nxt = 8'd0;
        end
      end
      GRANT: begin
        // A dropped request ends the tenure without timeout, even when the
        // hold limit is reached in the same cycle.
        if (!req[grant_id] || hold_cnt >= HOLD_LIM) begin
          state_nxt    = GAP;
          grant_nxt    = 16'd0;
          id_nxt       = 4'd0;
          valid_nxt    = 1'b0;
          hold_cnt_nxt = 8'd0;
          timeout_nxt  = req[grant_id];
        end else if (hold_cnt != 8'hFF) begin
          hold_cnt_nxt = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        grant_nxt    = 16'd0;
        id_nxt       = 4'd0;
        valid_nxt    = 1'b0;
        hold_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= 16'd0;
      grant_id    <= 4'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      last_id     <= 4'd0;
      hold_cnt    <= 8'd0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_id    <= id_nxt;
      grant_valid <= valid_nxt;
      timeout     <= timeout_nxt;
      last_id     <= last_id_nxt;
      hold_cnt    <= hold_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_clocked_priority_arbiter_16.sv
// Bench for clocked_priority_arbiter_16. Three instances share the clock and
// reset: a uses MAX_HOLD=8, b uses MAX_HOLD=3, and c uses MAX_HOLD=2.
module tb_clocked_priority_arbiter_16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req_a, req_b, req_c;
  logic        rr_a, rr_b, rr_c;
  logic [15:0] grant_a, grant_b, grant_c;
  logic [3:0]  id_a, id_b, id_c;
  logic        valid_a, valid_b, valid_c;
  logic        to_a, to_b, to_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clocked_priority_arbiter_16 u_a (
    .clk(clk), .reset(reset), .req(req_a), .rr_en(rr_a),
    .grant(grant_a), .grant_id(id_a), .grant_valid(valid_a), .timeout(to_a));

  clocked_priority_arbiter_16 #(.MAX_HOLD(3)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .rr_en(rr_b),
    .grant(grant_b), .grant_id(id_b), .grant_valid(valid_b), .timeout(to_b));

  clocked_priority_arbiter_16 #(.MAX_HOLD(2)) u_c (
    .clk(clk), .reset(reset), .req(req_c), .rr_en(rr_c),
    .grant(grant_c), .grant_id(id_c), .grant_valid(valid_c), .timeout(to_c));

  typedef struct {
    logic [15:0] req;
    logic        rr;
    logic [15:0] grant;
    logic [3:0]  id;
    logic        valid;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] g, input logic [3:0] id,
                           input logic v, input logic to,
                           input logic [15:0] eg, input logic [3:0] eid,
                           input logic ev, input logic eto);
    check({tag, ".grant"}, 32'(g), 32'(eg));
    check({tag, ".grant_id"}, 32'(id), 32'(eid));
    check({tag, ".grant_valid"}, 32'(v), 32'(ev));
    check({tag, ".timeout"}, 32'(to), 32'(eto));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // The round-robin expectations follow the last_id chain through the table,
    // starting from last_id = 0 after reset.
    vecs[0]  = '{16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0};
    vecs[1]  = '{16'h8101, 1'b0, 16'h8000, 4'd15, 1'b1};
    vecs[2]  = '{16'h0101, 1'b0, 16'h0100, 4'd8,  1'b1};
    vecs[3]  = '{16'h0001, 1'b0, 16'h0001, 4'd0,  1'b1};
    vecs[4]  = '{16'h0003, 1'b1, 16'h0002, 4'd1,  1'b1};
    vecs[5]  = '{16'h0003, 1'b1, 16'h0001, 4'd0,  1'b1};
    vecs[6]  = '{16'h8001, 1'b1, 16'h8000, 4'd15, 1'b1};
    vecs[7]  = '{16'h8001, 1'b1, 16'h0001, 4'd0,  1'b1};
    vecs[8]  = '{16'h0400, 1'b0, 16'h0400, 4'd10, 1'b1};
    vecs[9]  = '{16'h0C00, 1'b1, 16'h0800, 4'd11, 1'b1};
    vecs[10] = '{16'h0C00, 1'b1, 16'h0400, 4'd10, 1'b1};
    vecs[11] = '{16'hFFFF, 1'b0, 16'h8000, 4'd15, 1'b1};

    reset = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    rr_a = 1'b0; rr_b = 1'b0; rr_c = 1'b0;

    // Reset state. req is non-zero here, yet reset must keep everything clear.
    req_a = 16'hFFFF;
    tick();
    tick();
    check_out("reset", grant_a, id_a, valid_a, to_a, 16'h0, 4'd0, 1'b0, 1'b0);
    req_a = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;

    // Table vectors, applied from IDLE on dut a.
    for (int v = 0; v < 12; v++) begin
      req_a = vecs[v].req;
      rr_a  = vecs[v].rr;
      tick();
      check_out($sformatf("vec%0d", v), grant_a, id_a, valid_a, to_a,
                vecs[v].grant, vecs[v].id, vecs[v].valid, 1'b0);
      req_a = '0;
      tick();
      tick();
    end

    // Fixed priority hold, then release into a gap and a regrant to id 8.
    rr_a  = 1'b0;
    req_a = 16'h8101;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_out($sformatf("fp_hold%0d", c), grant_a, id_a, valid_a, to_a,
                16'h8000, 4'd15, 1'b1, 1'b0);
    end
    req_a = 16'h0101;
    tick();
    check_out("fp_gap", grant_a, id_a, valid_a, to_a, 16'h0, 4'd0, 1'b0, 1'b0);
    tick();
    check_out("fp_regrant", grant_a, id_a, valid_a, to_a, 16'h0100, 4'd8, 1'b1, 1'b0);

    // Asynchronous reset between edges, in the middle of the id 8 tenure.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_out("async_rst", grant_a, id_a, valid_a, to_a, 16'h0, 4'd0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    reset = 1'b1;
    req_a = 16'h0003;
    rr_a  = 1'b1;
    tick();
    check_out("post_rst", grant_a, id_a, valid_a, to_a, 16'h0002, 4'd1, 1'b1, 1'b0);
    req_a = '0;
    tick();

    // Timeout on dut b with MAX_HOLD=3.
    req_b = 16'h0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_out($sformatf("to_grant%0d", c), grant_b, id_b, valid_b, to_b,
                16'h0010, 4'd4, 1'b1, 1'b0);
    end
    tick();
    check_out("to_pulse", grant_b, id_b, valid_b, to_b, 16'h0, 4'd0, 1'b0, 1'b1);
    tick();
    check_out("to_regrant", grant_b, id_b, valid_b, to_b, 16'h0010, 4'd4, 1'b1, 1'b0);
    req_b = '0;

    // Round-robin rotation on dut c with MAX_HOLD=2. Each id is held for two
    // cycles, followed by one GAP cycle that carries the timeout pulse.
    rr_c  = 1'b1;
    req_c = 16'hFFFF;
    for (int t = 0; t < 17; t++) begin
      logic [3:0]  eid;
      logic [15:0] eg;
      eid = 4'(15 - (t % 16));
      eg  = 16'd1 << eid;
      tick();
      check_out($sformatf("rr%0d_c1", t), grant_c, id_c, valid_c, to_c, eg, eid, 1'b1, 1'b0);
      tick();
      check_out($sformatf("rr%0d_c2", t), grant_c, id_c, valid_c, to_c, eg, eid, 1'b1, 1'b0);
      tick();
      check_out($sformatf("rr%0d_gap", t), grant_c, id_c, valid_c, to_c, 16'h0, 4'd0, 1'b0, 1'b1);
    end

    // The request drops on the cycle the hold limit is reached, so no timeout.
    req_c = 16'h0020;
    tick();
    check_out("drop_c1", grant_c, id_c, valid_c, to_c, 16'h0020, 4'd5, 1'b1, 1'b0);
    tick();
    check_out("drop_c2", grant_c, id_c, valid_c, to_c, 16'h0020, 4'd5, 1'b1, 1'b0);
    req_c = '0;
    tick();
    check_out("drop_gap", grant_c, id_c, valid_c, to_c, 16'h0, 4'd0, 1'b0, 1'b0);
    tick();
    check_out("drop_idle", grant_c, id_c, valid_c, to_c, 16'h0, 4'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
